m_reg_decode_stage: RTL and testbench
=====================================

# m_reg_decode_stage

Registered, hazard-aware successor to the combinational register-field decoder. Accepts one instruction per cycle over a valid/ready handshake and extracts the destination (rd) and two source (rs, rq) register indices, with per-field use flags. A busy-register scoreboard stalls issue on RAW/WAW hazards until writeback clears them. Sits between fetch/kind-classification and the register-file read stage.

## Interface
Parameters:
- REG_BITS, 5, register index width; register file holds 2**REG_BITS entries.
- FIELD_LSB, 8, bit position of the rd field in the instruction word.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage accepts this cycle.
- in_kind  in  e_kind  instruction kind (p_instruction).
- in_instruction  in  32  raw instruction word.
- out_valid  out  1  decoded result held.
- out_ready  in  1  downstream consumes this cycle.
- out_kind  out  e_kind  registered kind.
- out_instruction  out  32  registered instruction word.
- out_rd, out_rs, out_rq  out  REG_BITS each  decoded indices.
- out_use_rd, out_use_rs, out_use_rq  out  1 each  field valid flags.
- wb_valid  in  1  a register write has completed.
- wb_rd  in  REG_BITS  register written back.
- flush  in  1  synchronous pipeline flush.

## Operation
- Field positions: rd = instruction[FIELD_LSB +: REG_BITS], rs = [FIELD_LSB+REG_BITS +: REG_BITS], rq = [FIELD_LSB+2*REG_BITS +: REG_BITS].
- Use flags by kind: KIND_RRR → rd, rs, rq; KIND_RRI → rd, rs; KIND_RI → rd; all other kinds → none. Unused fields are output as 0.
- Register 0 is hardwired zero: it never becomes busy and never causes a hazard.
- Scoreboard: busy[2**REG_BITS-1:0].
  - Effective busy = busy with wb_rd cleared when wb_valid (same-cycle writeback is visible to the hazard check).
  - hazard = any used, non-zero field (rd, rs, rq) whose effective busy bit is set.
- in_ready = !hazard && (!out_valid || out_ready) && !flush.
- Accept (in_valid && in_ready): load all output registers, set out_valid, and set busy[rd] if use_rd and rd != 0.
- Consume without accept: clear out_valid.
- Same register cleared by wb and set by accept in one cycle: set wins.
- flush: clears out_valid and all busy bits; in_ready is 0 that cycle; wb is ignored.
- wb_valid for a non-busy register or for register 0: no effect.

## Timing
- Reset: out_valid=0, all out_* fields/flags=0, out_kind=0 encoding, busy=0.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 per cycle when hazard-free and downstream ready.
- Holding: while out_valid && !out_ready, all out_* are stable.
- Upstream must hold in_* stable while in_valid && !in_ready.
- Reset asserted mid-transfer: all state clears immediately; the in-flight instruction is lost.

## Structure
- Add to p_instruction: e_kind members KIND_RRI and KIND_RI (KIND_RRR exists), plus a s_reg_fields struct (rd/rs/rq plus use flags).
- Sub-module m_reg_scoreboard: busy vector, set/clear/flush, and the combinational hazard query. The field decode function lives in the top module.

## Test plan
- Reset: assert rst mid-stream → out_valid=0, busy=0 next observation, in_ready=1.
- RRR 0x001C_4300 (rd=3, rs=2, rq=7) accepted, out_ready=1 → next cycle out_rd=3, out_rs=2, out_rq=7, all use=1, busy[3]=1.
- RAW: second RRR reading rs=3 while busy[3] → in_ready=0; assert wb_valid, wb_rd=3 → accepted that same cycle.
- Backpressure: out_ready=0 for 4 cycles → outputs stable, in_ready=0; release → next instruction accepted the same cycle.
- Register 0: RI with rd=0 is accepted back-to-back ×3 with no stall; busy stays 0.
- Flush with busy[5]=1 and out_valid=1 → next cycle out_valid=0, busy=0; an RRR reading r5 is accepted immediately.

Source files
------------

// File: rtl/m_reg_decode_stage_pkg.sv
// Shared instruction-kind encoding and the decoded register-field bundle
// used by the decode stage and its scoreboard.
package p_instruction;

  typedef enum logic [2:0] {
    KIND_NONE  = 3'd0,
    KIND_RRR   = 3'd1,
    KIND_RRI   = 3'd2,
    KIND_RI    = 3'd3,
    KIND_MEM   = 3'd4,
    KIND_JUMP  = 3'd5
  } e_kind;

  localparam int unsigned DEF_REG_BITS  = 5;
  localparam int unsigned DEF_FIELD_LSB = 8;

  typedef struct packed {
    logic [DEF_REG_BITS-1:0] rd;
    logic [DEF_REG_BITS-1:0] rs;
    logic [DEF_REG_BITS-1:0] rq;
    logic                    use_rd;
    logic                    use_rs;
    logic                    use_rq;
  } s_reg_fields;

endpackage

// File: rtl/m_reg_decode_stage_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register, set on issue,
// cleared on writeback, wiped on flush, with a combinational hazard query.
module m_reg_scoreboard #(
  parameter int unsigned REG_BITS = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   set_valid,
  input  logic [REG_BITS-1:0]    set_rd,
  input  logic                   wb_valid,
  input  logic [REG_BITS-1:0]    wb_rd,
  input  logic [REG_BITS-1:0]    q_rd,
  input  logic [REG_BITS-1:0]    q_rs,
  input  logic [REG_BITS-1:0]    q_rq,
  input  logic                   q_use_rd,
  input  logic                   q_use_rs,
  input  logic                   q_use_rq,
  output logic                   hazard,
  output logic [2**REG_BITS-1:0] busy
);

  localparam int unsigned NREGS = 2**REG_BITS;

  logic [NREGS-1:0] wb_mask;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] eff_busy;
  logic [NREGS-1:0] busy_next;

  // Writeback in the same cycle is visible to the query, so a stalled reader
  // issues in the cycle its operand is written back.
  always_comb begin
    wb_mask  = '0;
    set_mask = '0;
    if (wb_valid)  wb_mask[wb_rd]   = 1'b1;
    if (set_valid) set_mask[set_rd] = 1'b1;
    eff_busy     = busy & ~wb_mask;
    busy_next    = eff_busy | set_mask;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    hazard = 1'b0;
    if (q_use_rd && (q_rd != '0) && eff_busy[q_rd]) hazard = 1'b1;
    if (q_use_rs && (q_rs != '0) && eff_busy[q_rs]) hazard = 1'b1;
    if (q_use_rq && (q_rq != '0) && eff_busy[q_rq]) hazard = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: rtl/m_reg_decode_stage.sv
// Registered register-field decode stage with a busy scoreboard that stalls
// issue on RAW/WAW hazards until writeback.
// Handshake: a transfer happens on a cycle where valid && ready are both high;
// the producer holds its payload stable while valid && !ready.
module m_reg_decode_stage
  import p_instruction::*;
#(
  parameter int unsigned REG_BITS  = 5,
  parameter int unsigned FIELD_LSB = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  e_kind               in_kind,
  input  logic [31:0]         in_instruction,
  output logic                out_valid,
  input  logic                out_ready,
  output e_kind               out_kind,
  output logic [31:0]         out_instruction,
  output logic [REG_BITS-1:0] out_rd,
  output logic [REG_BITS-1:0] out_rs,
  output logic [REG_BITS-1:0] out_rq,
  output logic                out_use_rd,
  output logic                out_use_rs,
  output logic                out_use_rq,
  input  logic                wb_valid,
  input  logic [REG_BITS-1:0] wb_rd,
  input  logic                flush
);

  typedef struct packed {
    logic [REG_BITS-1:0] rd;
    logic [REG_BITS-1:0] rs;
    logic [REG_BITS-1:0] rq;
    logic                use_rd;
    logic                use_rs;
    logic                use_rq;
  } s_fields_t;

  // Unused fields are zeroed so downstream never sees stale index bits.
  function automatic s_fields_t decode_fields(input e_kind kind, input logic [31:0] instr);
    s_fields_t f;
    f        = '0;
    f.use_rd = (kind == KIND_RRR) || (kind == KIND_RRI) || (kind == KIND_RI);
    f.use_rs = (kind == KIND_RRR) || (kind == KIND_RRI);
    f.use_rq = (kind == KIND_RRR);
    if (f.use_rd) f.rd = instr[FIELD_LSB +: REG_BITS];
    if (f.use_rs) f.rs = instr[FIELD_LSB + REG_BITS +: REG_BITS];
    if (f.use_rq) f.rq = instr[FIELD_LSB + 2*REG_BITS +: REG_BITS];
    return f;
  endfunction

  s_fields_t           dec;
  logic                hazard;
  logic                accept;
  logic                set_valid;
  logic [2**REG_BITS-1:0] busy;

  assign dec       = decode_fields(in_kind, in_instruction);
  assign in_ready  = !hazard && (!out_valid || out_ready) && !flush;
  assign accept    = in_valid && in_ready;
  assign set_valid = accept && dec.use_rd && (dec.rd != '0);

  m_reg_scoreboard #(.REG_BITS(REG_BITS)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .set_valid (set_valid),
    .set_rd    (dec.rd),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .q_rd      (dec.rd),
    .q_rs      (dec.rs),
    .q_rq      (dec.rq),
    .q_use_rd  (dec.use_rd),
    .q_use_rs  (dec.use_rs),
    .q_use_rq  (dec.use_rq),
    .hazard    (hazard),
    .busy      (busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Payload only moves on accept, which keeps it stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_kind        <= KIND_NONE;
      out_instruction <= '0;
      out_rd          <= '0;
      out_rs          <= '0;
      out_rq          <= '0;
      out_use_rd      <= 1'b0;
      out_use_rs      <= 1'b0;
      out_use_rq      <= 1'b0;
    end else if (accept) begin
      out_kind        <= in_kind;
      out_instruction <= in_instruction;
      out_rd          <= dec.rd;
      out_rs          <= dec.rs;
      out_rq          <= dec.rq;
      out_use_rd      <= dec.use_rd;
      out_use_rs      <= dec.use_rs;
      out_use_rq      <= dec.use_rq;
    end
  end

endmodule

// File: tb/tb_m_reg_decode_stage.sv
// Directed bench for m_reg_decode_stage: decode, hazard stall/release,
// backpressure, register-0 handling, flush and asynchronous reset.
module tb_m_reg_decode_stage;
  import p_instruction::*;

  localparam int unsigned REG_BITS  = 5;
  localparam int unsigned FIELD_LSB = 8;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  e_kind               in_kind;
  logic [31:0]         in_instruction;
  logic                out_valid;
  logic                out_ready;
  e_kind               out_kind;
  logic [31:0]         out_instruction;
  logic [REG_BITS-1:0] out_rd, out_rs, out_rq;
  logic                out_use_rd, out_use_rs, out_use_rq;
  logic                wb_valid;
  logic [REG_BITS-1:0] wb_rd;
  logic                flush;

  int checks   = 0;
  int failures = 0;

  m_reg_decode_stage #(.REG_BITS(REG_BITS), .FIELD_LSB(FIELD_LSB)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_kind         (in_kind),
    .in_instruction  (in_instruction),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_kind        (out_kind),
    .out_instruction (out_instruction),
    .out_rd          (out_rd),
    .out_rs          (out_rs),
    .out_rq          (out_rq),
    .out_use_rd      (out_use_rd),
    .out_use_rs      (out_use_rs),
    .out_use_rq      (out_use_rq),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .flush           (flush)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input e_kind k, input logic [31:0] instr);
    in_valid       = 1'b1;
    in_kind        = k;
    in_instruction = instr;
    #1;
  endtask

  task automatic idle();
    in_valid       = 1'b0;
    in_kind        = KIND_NONE;
    in_instruction = '0;
  endtask

  task automatic check_out(input string tag, input logic [4:0] rd, input logic [4:0] rs,
                           input logic [4:0] rq, input logic [2:0] uses);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_rd"}, 32'(out_rd), 32'(rd));
    check({tag, "_rs"}, 32'(out_rs), 32'(rs));
    check({tag, "_rq"}, 32'(out_rq), 32'(rq));
    check({tag, "_use"}, {29'd0, out_use_rd, out_use_rs, out_use_rq}, 32'(uses));
  endtask

  task automatic check_busy(input string tag, input logic [31:0] exp);
    check(tag, u_dut.u_sb.busy, exp);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_kind", 32'(out_kind), 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    check_busy("rst_busy", 32'd0);

    // RRR rd=3 rs=2 rq=7
    @(posedge clk); #1;
    drive(KIND_RRR, 32'h001C_4300);
    check("rrr_in_ready", 32'(in_ready), 32'd1);
    tick();
    idle();
    check_out("rrr", 5'd3, 5'd2, 5'd7, 3'b111);
    check("rrr_kind", 32'(out_kind), 32'(KIND_RRR));
    check("rrr_instr", out_instruction, 32'h001C_4300);
    check_busy("rrr_busy", 32'h0000_0008);

    // RAW on r3: rd=4 rs=3 rq=1
    drive(KIND_RRR, 32'h0004_6400);
    check("raw_stall", 32'(in_ready), 32'd0);
    tick();
    check("raw_drained", 32'(out_valid), 32'd0);
    check("raw_still_stall", 32'(in_ready), 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd3;
    #1;
    check("raw_wb_release", 32'(in_ready), 32'd1);
    tick();
    wb_valid = 1'b0; idle();
    check_out("raw", 5'd4, 5'd3, 5'd1, 3'b111);
    check_busy("raw_busy", 32'h0000_0010);

    // Backpressure: RI rd=6 with junk rs bits, held for 4 cycles
    out_ready = 1'b0;
    drive(KIND_RI, 32'h0001_2600);
    for (int i = 0; i < 4; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_rd", 32'(out_rd), 32'd4);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release", 32'(in_ready), 32'd1);
    tick();
    idle();
    check_out("bp", 5'd6, 5'd0, 5'd0, 3'b100);
    check_busy("bp_busy", 32'h0000_0050);

    // Register 0: three back-to-back RI rd=0
    drive(KIND_RI, 32'h0000_2000);
    for (int i = 0; i < 3; i++) begin
      check("r0_in_ready", 32'(in_ready), 32'd1);
      tick();
      check_out("r0", 5'd0, 5'd0, 5'd0, 3'b100);
    end
    idle();
    check_busy("r0_busy", 32'h0000_0050);

    // Writebacks: r4, r6, then stray wb to non-busy r9 and r0
    wb_valid = 1'b1; wb_rd = 5'd4; tick();
    wb_rd = 5'd6; tick();
    wb_rd = 5'd9; tick();
    wb_rd = 5'd0; tick();
    wb_valid = 1'b0;
    check_busy("wb_busy", 32'd0);
    check("wb_drained", 32'(out_valid), 32'd0);

    // RRI rd=5 rs=0, rq bits must be zeroed
    drive(KIND_RRI, 32'h001C_0500);
    check("rri_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    tick();
    idle();
    check_out("rri", 5'd5, 5'd0, 5'd0, 3'b110);
    check_busy("rri_busy", 32'h0000_0020);

    // Flush while out_valid=1 and busy[5]=1; RRR rd=1 rs=5 rq=5 waits
    flush = 1'b1;
    drive(KIND_RRR, 32'h0014_A100);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check_busy("flush_busy", 32'd0);
    check("flush_accept", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick();
    idle();
    check_out("post_flush", 5'd1, 5'd5, 5'd5, 3'b111);
    check_busy("post_flush_busy", 32'h0000_0002);

    // Same-cycle wb and set on r1: set wins
    wb_valid = 1'b1; wb_rd = 5'd1;
    drive(KIND_RI, 32'h0000_0100);
    check("setwins_in_ready", 32'(in_ready), 32'd1);
    tick();
    wb_valid = 1'b0; idle();
    check_busy("setwins_busy", 32'h0000_0002);

    // Asynchronous reset mid-transfer
    out_ready = 1'b0;
    drive(KIND_RI, 32'h0000_0700);
    #1 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_rd", 32'(out_rd), 32'd0);
    check_busy("arst_busy", 32'd0);
    idle();
    tick();
    rst = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
